// File: rtl/cu_pkg.sv
// Shared definitions for the phase-1 control unit: opcodes, ALU codes, IR fields, states.
// The T6 state exists only when CU_MULDIV_EN is defined.
package cu_pkg;

  localparam int OP_HI = 31;
  localparam int OP_LO = 27;
  localparam int RA_HI = 26;
  localparam int RA_LO = 23;
  localparam int RB_HI = 22;
  localparam int RB_LO = 19;
  localparam int RC_HI = 18;
  localparam int RC_LO = 15;

  localparam logic [4:0] OP_ADD  = 5'b00100;
  localparam logic [4:0] OP_SUB  = 5'b00101;
  localparam logic [4:0] OP_AND  = 5'b00110;
  localparam logic [4:0] OP_OR   = 5'b00111;
  localparam logic [4:0] OP_SHR  = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [3:0] ALU_NONE = 4'h0;
  localparam logic [3:0] ALU_ADD  = 4'h1;
  localparam logic [3:0] ALU_SUB  = 4'h2;
  localparam logic [3:0] ALU_AND  = 4'h3;
  localparam logic [3:0] ALU_OR   = 4'h4;
  localparam logic [3:0] ALU_SHR  = 4'h5;
  localparam logic [3:0] ALU_SHL  = 4'h6;
  localparam logic [3:0] ALU_MUL  = 4'h7;
  localparam logic [3:0] ALU_DIV  = 4'h8;

  typedef enum logic [3:0] {
    ST_RESET,
    ST_T0,
    ST_T1,
    ST_T2,
    ST_T3,
    ST_T4,
    ST_T5,
`ifdef CU_MULDIV_EN
    ST_T6,
`endif
    ST_HALT
  } state_t;

  function automatic logic [3:0] alu_code(input logic [4:0] op);
    logic [3:0] code;
    code = ALU_NONE;
    case (op)
      OP_ADD:  code = ALU_ADD;
      OP_SUB:  code = ALU_SUB;
      OP_AND:  code = ALU_AND;
      OP_OR:   code = ALU_OR;
      OP_SHR:  code = ALU_SHR;
      OP_SHL:  code = ALU_SHL;
      OP_MUL:  code = ALU_MUL;
      OP_DIV:  code = ALU_DIV;
      default: code = ALU_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/reg_select.sv
// Turns the IR register fields plus Gra/Grb/Grc and Rin/Rout into one-hot
// R0-R15 load and bus-drive enables; all-zero whenever no field is selected.
module reg_select (
  input  logic [3:0]  ra_i,
  input  logic [3:0]  rb_i,
  input  logic [3:0]  rc_i,
  input  logic        gra_i,
  input  logic        grb_i,
  input  logic        grc_i,
  input  logic        rin_i,
  input  logic        rout_i,
  output logic [15:0] reg_in_o,
  output logic [15:0] reg_out_o
);

  logic [3:0] sel;
  logic       any_sel;

  always_comb begin
    sel     = 4'd0;
    any_sel = 1'b0;
    if (gra_i) begin
      sel     = ra_i;
      any_sel = 1'b1;
    end else if (grb_i) begin
      sel     = rb_i;
      any_sel = 1'b1;
    end else if (grc_i) begin
      sel     = rc_i;
      any_sel = 1'b1;
    end
  end

  assign reg_in_o  = (rin_i  && any_sel) ? (16'h0001 << sel) : 16'h0000;
  assign reg_out_o = (rout_i && any_sel) ? (16'h0001 << sel) : 16'h0000;

endmodule

// File: rtl/control_unit.sv
// Moore sequencer driving the phase-1 datapath strobes, with start/stop and a retired counter.
// Define CU_MULDIV_EN to decode MUL/DIV (adds T6 and the HI/LO/ZHigh strobes).
module control_unit
  import cu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [31:0]      ir,
  input  logic             start,
  input  logic             stop,
  output logic             PCout,
  output logic             PCin,
  output logic             IncPC,
  output logic             MARin,
  output logic             Read,
  output logic             MDRin,
  output logic             MDRout,
  output logic             IRin,
  output logic             Yin,
  output logic             ZLowIn,
  output logic             ZHighIn,
  output logic             ZLowOut,
  output logic             ZHighOut,
  output logic             LOin,
  output logic             HIin,
  output logic [3:0]       alu_op,
  output logic [15:0]      reg_in,
  output logic [15:0]      reg_out,
  output logic             run,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  state_t           state_q, state_d;
  logic             stop_seen_q, stop_seen_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic [4:0] opcode;
  logic       op_alu, op_md, op_nop, op_halt, op_ill;
  logic       last, gra, grb, grc, rin, rout;
  logic       ir_unused;

  assign opcode    = ir[OP_HI:OP_LO];
  assign ir_unused = ^ir[RC_LO-1:0];

  assign op_alu  = (opcode >= OP_ADD) && (opcode <= OP_SHL);
`ifdef CU_MULDIV_EN
  assign op_md   = (opcode == OP_MUL) || (opcode == OP_DIV);
`else
  assign op_md   = 1'b0;
`endif
  assign op_nop  = (opcode == OP_NOP);
  assign op_halt = (opcode == OP_HALT);
  assign op_ill  = !(op_alu || op_md || op_nop || op_halt);

  always_comb begin
    last = 1'b0;
    case (state_q)
      ST_T3:   last = !(op_alu || op_md);
      ST_T5:   last = !op_md;
`ifdef CU_MULDIV_EN
      ST_T6:   last = 1'b1;
`endif
      default: last = 1'b0;
    endcase
  end

  // A stop seen in any cycle of the instruction (including the last one) ends in HALT.
  always_comb begin
    state_d     = state_q;
    stop_seen_d = 1'b0;
    retired_d   = retired_q + {{(CNT_W-1){1'b0}}, last};
    if (run)
      stop_seen_d = last ? 1'b0 : (stop_seen_q || stop);
    if (last) begin
      state_d = (stop_seen_q || stop || op_halt) ? ST_HALT : ST_T0;
    end else begin
      case (state_q)
        ST_RESET: state_d = ST_T0;
        ST_T0:    state_d = ST_T1;
        ST_T1:    state_d = ST_T2;
        ST_T2:    state_d = ST_T3;
        ST_T3:    state_d = ST_T4;
        ST_T4:    state_d = ST_T5;
`ifdef CU_MULDIV_EN
        ST_T5:    state_d = ST_T6;
`endif
        ST_HALT:  state_d = (start && !stop) ? ST_T0 : ST_HALT;
        default:  state_d = ST_RESET;
      endcase
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q     <= ST_RESET;
      stop_seen_q <= 1'b0;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      stop_seen_q <= stop_seen_d;
      retired_q   <= retired_d;
    end
  end

  assign run     = (state_q != ST_RESET) && (state_q != ST_HALT);
  assign retired = retired_q;

  always_comb begin
    PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0; MARin = 1'b0; Read = 1'b0;
    MDRin = 1'b0; MDRout = 1'b0; IRin = 1'b0; Yin = 1'b0; ZLowIn = 1'b0;
    ZHighIn = 1'b0; ZLowOut = 1'b0; ZHighOut = 1'b0; LOin = 1'b0; HIin = 1'b0;
    alu_op = ALU_NONE; illegal = 1'b0;
    gra = 1'b0; grb = 1'b0; grc = 1'b0; rin = 1'b0; rout = 1'b0;
    case (state_q)
      ST_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; ZLowIn = 1'b1;
      end
      ST_T1: begin
        ZLowOut = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
      end
      ST_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
      end
      ST_T3: begin
        if (op_alu || op_md) begin
          grb = 1'b1; rout = 1'b1; Yin = 1'b1;
        end
        illegal = op_ill;
      end
      ST_T4: begin
        grc = 1'b1; rout = 1'b1; ZLowIn = 1'b1;
        alu_op = alu_code(opcode);
`ifdef CU_MULDIV_EN
        ZHighIn = op_md;
`endif
      end
      ST_T5: begin
        ZLowOut = 1'b1;
`ifdef CU_MULDIV_EN
        LOin = op_md;
`endif
        gra = !op_md; rin = !op_md;
      end
`ifdef CU_MULDIV_EN
      ST_T6: begin
        ZHighOut = 1'b1; HIin = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  reg_select u_reg_select (
    .ra_i      (ir[RA_HI:RA_LO]),
    .rb_i      (ir[RB_HI:RB_LO]),
    .rc_i      (ir[RC_HI:RC_LO]),
    .gra_i     (gra),
    .grb_i     (grb),
    .grc_i     (grc),
    .rin_i     (rin),
    .rout_i    (rout),
    .reg_in_o  (reg_in),
    .reg_out_o (reg_out)
  );

endmodule

// File: tb/tb_control_unit.sv
// Randomized self-checking bench for control_unit against a per-phase instruction model.
// Honors CU_MULDIV_EN the same way as the design build.
module tb_control_unit;
  import cu_pkg::*;

  localparam int TB_CNT_W = 8;
`ifdef CU_MULDIV_EN
  localparam bit MD_ON = 1'b1;
`else
  localparam bit MD_ON = 1'b0;
`endif

  localparam int S_PCOUT = 14, S_PCIN = 13, S_INCPC = 12, S_MARIN = 11, S_READ = 10;
  localparam int S_MDRIN = 9, S_MDROUT = 8, S_IRIN = 7, S_YIN = 6, S_ZLIN = 5;
  localparam int S_ZHIN = 4, S_ZLOUT = 3, S_ZHOUT = 2, S_LOIN = 1, S_HIIN = 0;

  typedef struct packed {
    logic [14:0] strb;
    logic [3:0]  alu;
    logic [15:0] rin;
    logic [15:0] rout;
    logic        run;
    logic        ill;
  } obs_t;

  logic clock, clear, start, stop;
  logic [31:0] ir;
  logic PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin, Yin;
  logic ZLowIn, ZHighIn, ZLowOut, ZHighOut, LOin, HIin, run, illegal;
  logic [3:0] alu_op;
  logic [15:0] reg_in, reg_out;
  logic [TB_CNT_W-1:0] retired;
  obs_t obs;

  int n_chk = 0;
  int n_bad = 0;
  logic [TB_CNT_W-1:0] exp_ret;

  control_unit #(.CNT_W(TB_CNT_W)) dut (
    .clock(clock), .clear(clear), .ir(ir), .start(start), .stop(stop),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .Read(Read),
    .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .ZLowIn(ZLowIn),
    .ZHighIn(ZHighIn), .ZLowOut(ZLowOut), .ZHighOut(ZHighOut), .LOin(LOin), .HIin(HIin),
    .alu_op(alu_op), .reg_in(reg_in), .reg_out(reg_out), .run(run), .illegal(illegal),
    .retired(retired)
  );

  assign obs = {PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin, Yin, ZLowIn,
                ZHighIn, ZLowOut, ZHighOut, LOin, HIin, alu_op, reg_in, reg_out, run, illegal};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit is_alu(input logic [4:0] op);
    return (op == 5'd4) || (op == 5'd5) || (op == 5'd6) || (op == 5'd7) || (op == 5'd8) || (op == 5'd9);
  endfunction

  function automatic bit is_md(input logic [4:0] op);
    return MD_ON && ((op == 5'd14) || (op == 5'd15));
  endfunction

  function automatic int instr_len(input logic [31:0] v);
    if (is_alu(v[31:27])) return 6;
    if (is_md(v[31:27])) return 7;
    return 4;
  endfunction

  function automatic logic [3:0] exp_alu(input logic [4:0] op);
    case (op)
      5'd4:    return ALU_ADD;
      5'd5:    return ALU_SUB;
      5'd6:    return ALU_AND;
      5'd7:    return ALU_OR;
      5'd8:    return ALU_SHR;
      5'd9:    return ALU_SHL;
      5'd14:   return ALU_MUL;
      5'd15:   return ALU_DIV;
      default: return ALU_NONE;
    endcase
  endfunction

  // Expected outputs in cycle k (0 = T0) of the instruction held in v.
  function automatic obs_t model(input int k, input logic [31:0] v);
    obs_t o;
    logic [4:0] op;
    bit alu, md, quiet;
    o = '0;
    op = v[31:27];
    alu = is_alu(op);
    md = is_md(op);
    quiet = (op == 5'd26) || (op == 5'd27);
    o.run = 1'b1;
    case (k)
      0: begin o.strb[S_PCOUT] = 1; o.strb[S_MARIN] = 1; o.strb[S_INCPC] = 1; o.strb[S_ZLIN] = 1; end
      1: begin o.strb[S_ZLOUT] = 1; o.strb[S_PCIN] = 1; o.strb[S_READ] = 1; o.strb[S_MDRIN] = 1; end
      2: begin o.strb[S_MDROUT] = 1; o.strb[S_IRIN] = 1; end
      3: begin
        if (alu || md) begin
          o.rout = 16'h0001 << v[22:19];
          o.strb[S_YIN] = 1;
        end else if (!quiet) o.ill = 1;
      end
      4: begin
        o.rout = 16'h0001 << v[18:15];
        o.alu = exp_alu(op);
        o.strb[S_ZLIN] = 1;
        if (md) o.strb[S_ZHIN] = 1;
      end
      5: begin
        o.strb[S_ZLOUT] = 1;
        if (md) o.strb[S_LOIN] = 1;
        else o.rin = 16'h0001 << v[26:23];
      end
      6: begin o.strb[S_ZHOUT] = 1; o.strb[S_HIIN] = 1; end
      default: o = '0;
    endcase
    return o;
  endfunction

  // Entered at posedge+1 of T0; leaves at posedge+1 of the following state.
  task automatic run_instr(input logic [31:0] v, input int stop_k, output bit halted);
    int len;
    len = instr_len(v);
    ir = v;
    for (int k = 0; k < len; k++) begin
      check($sformatf("ph%0d_op%02h", k, v[31:27]), obs, model(k, v));
      stop = (k == stop_k);
      @(posedge clock); #1;
    end
    stop = 1'b0;
    exp_ret = exp_ret + 1'b1;
    check("retired", retired, exp_ret);
    halted = (stop_k >= 0 && stop_k < len) || (v[31:27] == 5'd27);
    if (halted) check("halt_idle", obs, '0);
  endtask

  task automatic wake(input bit with_stop);
    if (with_stop) begin
      start = 1'b1; stop = 1'b1;
      @(posedge clock); #1;
      check("stop_prio", obs, '0);
    end
    start = 1'b1; stop = 1'b0;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  initial begin
    logic [4:0] legal [8];
    bit h;
    legal = '{5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd14, 5'd15};
    clear = 1'b1; start = 1'b0; stop = 1'b0; ir = '0; exp_ret = '0;
    #3;
    check("clr_async", obs, '0);
    check("clr_ret", retired, '0);
    repeat (2) @(posedge clock);
    #2 clear = 1'b0;
    #1 check("reset_state", obs, '0);
    @(posedge clock); #1;

    run_instr(32'h222B8000, -1, h);
    run_instr(32'h71180000, -1, h);
    run_instr(32'h222B8000, 4, h);
    check("halted_after_stop", {63'd0, h}, 64'd1);
    check("run_low", {63'd0, run}, 64'd0);
    wake(1'b1);

    // clear during T4 of an ADD: everything drops without a clock edge
    ir = 32'h222B8000;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("abort_ph%0d", k), obs, model(k, ir));
      @(posedge clock); #1;
    end
    check("abort_t4", obs, model(4, ir));
    #2 clear = 1'b1;
    #1 check("abort_clr", obs, '0);
    check("abort_ret", retired, '0);
    exp_ret = '0;
    @(posedge clock); #1 clear = 1'b0;
    #1 check("abort_reset", obs, '0);
    @(posedge clock); #1;

    for (int i = 0; i < 320; i++) begin
      logic [31:0] v;
      int r, sk;
      v = $urandom;
      r = $urandom_range(0, 15);
      if (r < 8) v[31:27] = legal[r];
      else if (r < 11) v[31:27] = 5'd26;
      else if (r == 11) v[31:27] = 5'd27;
      sk = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 6)) : -1;
      run_instr(v, sk, h);
      if (h) wake(1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
